encoder_bank_ctrl: RTL and testbench

Multi-channel encoder front end and host read sequencer for the wheel/shaft encoders. Each channel synchronises and debounces its raw pin and counts clean rising edges in a wrapping counter. A single byte-wide read port, polled by the host microcontroller, returns any channel's count: a per-channel snapshot keeps 16-bit reads atomic, and a status register reports wrap events. Group clear of counts is also supported. The counters are clocked by `clk`; no logic is clocked by encoder signals.

---
 rtl/encoder_pkg.sv | 15 +
 rtl/enc_debounce.sv | 44 ++++
 rtl/encoder_bank_ctrl.sv | 137 +++++++++++++
 tb/tb_encoder_bank_ctrl.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/encoder_pkg.sv
// Shared definitions for the encoder bank: read sequencer states, status address
// and the data widths of the byte-wide host read port.
package encoder_pkg;

  localparam int CNT_W = 16;
  localparam int RD_W  = 8;
  localparam logic [3:0] STATUS_ADDR = 4'hF;

  typedef enum logic [1:0] {
    RD_IDLE  = 2'd0,
    RD_FETCH = 2'd1,
    RD_RESP  = 2'd2
  } rd_state_e;

endpackage

// File: rtl/enc_debounce.sv
// One encoder channel front end: two-flop synchroniser, stability counter and
// debounced level, plus a single-cycle pulse on the edge where clean goes 0->1.
module enc_debounce #(
  parameter int DEBOUNCE_CYCLES = 127
) (
  input  logic clk,
  input  logic reset,
  input  logic enc,
  output logic clean,
  output logic rise
);

  localparam logic [7:0] DB_LIMIT = 8'(DEBOUNCE_CYCLES);

  logic       sync1;
  logic       sync2;
  logic       cand;
  logic [7:0] dcnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      cand  <= 1'b0;
      dcnt  <= '0;
      clean <= 1'b0;
    end else begin
      sync1 <= enc;
      sync2 <= sync1;
      if (sync2 != cand) begin
        cand <= sync2;
        dcnt <= '0;
      end else if (dcnt == DB_LIMIT) begin
        clean <= cand;
      end else begin
        dcnt <= dcnt + 8'd1;
      end
    end
  end

  // Asserted in the cycle before clean rises so the counter steps on the same edge.
  assign rise = (sync2 == cand) && (dcnt == DB_LIMIT) && cand && !clean;

endmodule

// File: rtl/encoder_bank_ctrl.sv
// Multi-channel encoder counter bank with group clear, per-channel read snapshots,
// sticky wrap flags and a three-state byte-wide host read sequencer.
module encoder_bank_ctrl
  import encoder_pkg::*;
#(
  parameter int NUM_ENC         = 4,
  parameter int DEBOUNCE_CYCLES = 127,
  parameter int CNT_W           = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_ENC-1:0] enc,
  input  logic               rd_req,
  input  logic [3:0]         rd_addr,
  output logic               rd_busy,
  output logic               rd_valid,
  output logic [RD_W-1:0]    rd_data,
  input  logic               clr_req,
  input  logic [NUM_ENC-1:0] clr_mask,
  output logic [1:0]         dbg_state,
  output logic [NUM_ENC-1:0] dbg_clean
);

  // Handshake: rd_req is sampled only in IDLE; rd_busy covers FETCH and RESP, and
  // rd_valid is a one-cycle pulse in RESP during which rd_data carries the byte.

  rd_state_e state_q, state_d;
  logic [3:0]         addr_q;
  logic [RD_W-1:0]    rd_data_q;
  logic [RD_W-1:0]    rd_byte;
  logic [NUM_ENC-1:0] snap_sel;
  logic               status_clr;
  logic [NUM_ENC-1:0] rise;
  logic [NUM_ENC-1:0] clean;
  logic [NUM_ENC-1:0] ovf;
  logic [CNT_W-1:0]   count_arr [NUM_ENC];
  logic [CNT_W-1:0]   snap_arr  [NUM_ENC];

  for (genvar i = 0; i < NUM_ENC; i++) begin : g_ch
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] snap_q;
    logic             ovf_q;
    logic             clr_hit;

    enc_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_db (
      .clk  (clk),
      .reset(reset),
      .enc  (enc[i]),
      .clean(clean[i]),
      .rise (rise[i])
    );

    assign clr_hit = clr_req && clr_mask[i];

    // Snapshot and flag read-clear see pre-edge values; a new wrap beats read-clear.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        count_q <= '0;
        snap_q  <= '0;
        ovf_q   <= 1'b0;
      end else begin
        if (clr_hit) begin
          count_q <= '0;
        end else if (rise[i]) begin
          count_q <= count_q + 1'b1;
        end
        if (snap_sel[i]) begin
          snap_q <= count_q;
        end
        if (rise[i] && !clr_hit && (count_q == '1)) begin
          ovf_q <= 1'b1;
        end else if (status_clr) begin
          ovf_q <= 1'b0;
        end
      end
    end

    assign count_arr[i] = count_q;
    assign snap_arr[i]  = snap_q;
    assign ovf[i]       = ovf_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= RD_IDLE;
      addr_q    <= '0;
      rd_data_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == RD_IDLE && rd_req) begin
        addr_q <= rd_addr;
      end
      if (state_q == RD_FETCH) begin
        rd_data_q <= rd_byte;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      RD_IDLE:  if (rd_req) state_d = RD_FETCH;
      RD_FETCH: state_d = RD_RESP;
      RD_RESP:  state_d = RD_IDLE;
      default:  state_d = RD_IDLE;
    endcase
  end

  // Address decode; side effects fire only while FETCH is active.
  always_comb begin
    rd_byte    = '0;
    snap_sel   = '0;
    status_clr = 1'b0;
    if (addr_q == STATUS_ADDR) begin
      rd_byte[NUM_ENC-1:0] = ovf;
      status_clr = (state_q == RD_FETCH);
    end else begin
      for (int i = 0; i < NUM_ENC; i++) begin
        if (addr_q == 4'(2 * i)) begin
          rd_byte     = count_arr[i][RD_W-1:0];
          snap_sel[i] = (state_q == RD_FETCH);
        end else if (addr_q == 4'(2 * i + 1)) begin
          rd_byte = snap_arr[i][CNT_W-1:RD_W];
        end
      end
    end
  end

  assign rd_busy   = (state_q != RD_IDLE);
  assign rd_valid  = (state_q == RD_RESP);
  assign rd_data   = rd_data_q;
  assign dbg_state = state_q;
  assign dbg_clean = clean;

endmodule

// File: tb/tb_encoder_bank_ctrl.sv
// Bench for encoder_bank_ctrl: reduced debounce length, read results checked
// through an expected-byte queue, feature scenarios as tasks.
module tb_encoder_bank_ctrl;

  localparam int NUM_ENC = 4;
  localparam int DEB     = 15;

  logic               clk = 1'b0;
  logic               reset;
  logic [NUM_ENC-1:0] enc;
  logic               rd_req;
  logic [3:0]         rd_addr;
  logic               rd_busy;
  logic               rd_valid;
  logic [7:0]         rd_data;
  logic               clr_req;
  logic [NUM_ENC-1:0] clr_mask;
  logic [1:0]         dbg_state;
  logic [NUM_ENC-1:0] dbg_clean;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];

  encoder_bank_ctrl #(
    .NUM_ENC(NUM_ENC),
    .DEBOUNCE_CYCLES(DEB),
    .CNT_W(16)
  ) dut (
    .clk(clk),
    .reset(reset),
    .enc(enc),
    .rd_req(rd_req),
    .rd_addr(rd_addr),
    .rd_busy(rd_busy),
    .rd_valid(rd_valid),
    .rd_data(rd_data),
    .clr_req(clr_req),
    .clr_mask(clr_mask),
    .dbg_state(dbg_state),
    .dbg_clean(dbg_clean)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL timeout: run did not finish, checks=%0d", checks);
    $fatal(1, "watchdog expired");
  end

  // scoreboard: every rd_valid pulse consumes one expected byte
  always @(negedge clk) begin
    if (rd_valid === 1'b1) begin
      logic [7:0] exp;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL rd_unexpected: rd_valid with data %02h, none expected", rd_data);
      end else begin
        exp = exp_q.pop_front();
        if (rd_data !== exp) begin
          errors++;
          $display("FAIL rd_data: got %02h expected %02h", rd_data, exp);
        end
      end
    end
  end

  // driver tasks
  task automatic do_read(input logic [3:0] addr, input logic [7:0] exp);
    @(negedge clk);
    rd_req  = 1'b1;
    rd_addr = addr;
    exp_q.push_back(exp);
    @(posedge clk);
    @(negedge clk);
    rd_req = 1'b0;
    checks++;
    if (rd_busy !== 1'b1 || rd_valid !== 1'b0) begin
      errors++;
      $display("FAIL rd_fetch_phase addr %h: busy=%b valid=%b expected busy=1 valid=0", addr, rd_busy, rd_valid);
    end
    @(negedge clk);
    checks++;
    if (rd_valid !== 1'b1) begin
      errors++;
      $display("FAIL rd_latency addr %h: valid=%b expected 1 two cycles after request", addr, rd_valid);
    end
    @(negedge clk);
    checks++;
    if (rd_valid !== 1'b0 || rd_busy !== 1'b0) begin
      errors++;
      $display("FAIL rd_done addr %h: busy=%b valid=%b expected 0/0", addr, rd_busy, rd_valid);
    end
  endtask

  task automatic drive_edges(input int ch, input int n, input int hi, input int lo);
    for (int k = 0; k < n; k++) begin
      enc[ch] = 1'b1;
      repeat (hi) @(negedge clk);
      enc[ch] = 1'b0;
      repeat (lo) @(negedge clk);
    end
  endtask

  // scenarios
  task automatic test_reset();
    reset    = 1'b1;
    enc      = '0;
    rd_req   = 1'b0;
    rd_addr  = '0;
    clr_req  = 1'b0;
    clr_mask = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    checks++;
    if (rd_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", rd_valid); end
    checks++;
    if (rd_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", rd_busy); end
    checks++;
    if (rd_data !== 8'h00) begin errors++; $display("FAIL reset_data: got %02h expected 00", rd_data); end
    checks++;
    if (dbg_state !== 2'd0) begin errors++; $display("FAIL reset_state: got %0d expected 0", dbg_state); end
    checks++;
    if (dut.g_ch[0].count_q !== 16'h0000) begin
      errors++; $display("FAIL reset_count: got %04h expected 0000", dut.g_ch[0].count_q);
    end
  endtask

  task automatic test_debounce_latency();
    @(negedge clk);
    enc[0] = 1'b1;
    repeat (DEB + 3) @(posedge clk);
    #1;
    checks++;
    if (dut.g_ch[0].count_q !== 16'h0000) begin
      errors++; $display("FAIL deb_early: count %04h expected 0000 one edge before acceptance", dut.g_ch[0].count_q);
    end
    @(posedge clk);
    #1;
    checks++;
    if (dut.g_ch[0].count_q !== 16'h0001) begin
      errors++; $display("FAIL deb_edge: count %04h expected 0001 at acceptance edge", dut.g_ch[0].count_q);
    end
    do_read(4'h0, 8'h01);
    do_read(4'h1, 8'h00);
  endtask

  task automatic test_glitch();
    @(negedge clk);
    enc[1] = 1'b1;
    repeat (DEB - 5) @(negedge clk);
    enc[1] = 1'b0;
    repeat (40) @(negedge clk);
    do_read(4'h2, 8'h00);
    @(negedge clk);
    drive_edges(1, 5, 20, 20);
    do_read(4'h2, 8'h05);
    do_read(4'h3, 8'h00);
  endtask

  task automatic test_snapshot();
    @(negedge clk);
    drive_edges(2, 300, 20, 20);
    do_read(4'h4, 8'h2C);
    @(negedge clk);
    drive_edges(2, 1, 20, 20);
    do_read(4'h5, 8'h01);
    do_read(4'h4, 8'h2D);
    do_read(4'h5, 8'h01);
  endtask

  task automatic test_overflow();
    @(negedge clk);
    force dut.g_ch[3].count_q = 16'hFFFE;
    @(negedge clk);
    release dut.g_ch[3].count_q;
    drive_edges(3, 2, 20, 20);
    do_read(4'h6, 8'h00);
    do_read(4'h7, 8'h00);
    do_read(4'hF, 8'h08);
    do_read(4'hF, 8'h00);
    do_read(4'hE, 8'h00);
  endtask

  task automatic test_clear_collision();
    @(negedge clk);
    enc[0] = 1'b0;
    repeat (DEB + 10) @(negedge clk);
    enc[0] = 1'b1;
    repeat (DEB + 3) @(posedge clk);
    @(negedge clk);
    clr_req  = 1'b1;
    clr_mask = 4'b0001;
    @(posedge clk);
    #1;
    clr_req  = 1'b0;
    clr_mask = '0;
    checks++;
    if (dut.g_ch[0].count_q !== 16'h0000) begin
      errors++; $display("FAIL clr_collide: count %04h expected 0000", dut.g_ch[0].count_q);
    end
    checks++;
    if (dbg_clean[0] !== 1'b1) begin
      errors++; $display("FAIL clr_clean: clean %b expected 1", dbg_clean[0]);
    end
    do_read(4'h0, 8'h00);
    do_read(4'h2, 8'h05);
    do_read(4'h4, 8'h2D);
    @(negedge clk);
    clr_req  = 1'b1;
    clr_mask = 4'b0010;
    @(negedge clk);
    clr_req  = 1'b0;
    clr_mask = '0;
    do_read(4'h2, 8'h00);
    do_read(4'h5, 8'h01);
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    rd_req  = 1'b1;
    rd_addr = 4'h4;
    exp_q.push_back(8'h2D);
    exp_q.push_back(8'h2D);
    repeat (6) @(posedge clk);
    @(negedge clk);
    rd_req = 1'b0;
    repeat (4) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL b2b_drain: %0d reads outstanding, expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset_mid_read();
    do_read(4'h4, 8'h2D);
    @(negedge clk);
    rd_req  = 1'b1;
    rd_addr = 4'h2;
    @(posedge clk);
    @(negedge clk);
    rd_req = 1'b0;
    reset  = 1'b1;
    #1;
    checks++;
    if (rd_busy !== 1'b0 || rd_valid !== 1'b0 || rd_data !== 8'h00 || dbg_state !== 2'd0) begin
      errors++;
      $display("FAIL reset_abort: busy=%b valid=%b data=%02h state=%0d expected all 0",
               rd_busy, rd_valid, rd_data, dbg_state);
    end
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (DEB + 10) @(negedge clk);
    do_read(4'h0, 8'h01);
    do_read(4'h4, 8'h00);
  endtask

  initial begin
    test_reset();
    test_debounce_latency();
    test_glitch();
    test_snapshot();
    test_overflow();
    test_clear_collision();
    test_back_to_back();
    test_reset_mid_read();
    repeat (4) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL final_drain: %0d reads never returned", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
